// File: rtl/apb_timer_slave.sv
// APB slave with a 32-bit down-counting timer (CTRL/LOAD/VALUE/INT) and a level interrupt.
// Optional ACCESS-phase wait states are compiled in with the APB_SLV_WAIT_EN macro.
module apb_timer_slave #(
    parameter int unsigned ADDRWIDTH   = 16,
    parameter int unsigned DATAWIDTH   = 32,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic                 hclk_i,
    input  logic                 hresetn_i,
    input  logic                 pclken_i,
    input  logic                 psel_i,
    input  logic                 penable_i,
    input  logic [ADDRWIDTH-1:0] paddr_i,
    input  logic                 pwrite_i,
    input  logic [DATAWIDTH-1:0] pwdata_i,
    output logic [DATAWIDTH-1:0] prdata_o,
    output logic                 pready_o,
    output logic                 pslverr_o,
    output logic                 timerint_o
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StSetup  = 2'd1;
    localparam logic [1:0] StAccess = 2'd2;

    localparam logic [1:0] AddrCtrl  = 2'd0;
    localparam logic [1:0] AddrLoad  = 2'd1;
    localparam logic [1:0] AddrValue = 2'd2;
    localparam logic [1:0] AddrInt   = 2'd3;

`ifdef APB_SLV_WAIT_EN
    localparam logic [3:0] WaitLoad = 4'(WAIT_STATES);
`else
    logic unused_wait_cfg;
    assign unused_wait_cfg = ^(32'(WAIT_STATES));
`endif

    logic [1:0]           state_q, state_d;
    logic [DATAWIDTH-1:0] prdata_q, prdata_d;
    logic                 pready_q, pready_d;
    logic                 pslverr_q, pslverr_d;
    logic                 err_q, err_d;
`ifdef APB_SLV_WAIT_EN
    logic [3:0]           wait_cnt_q, wait_cnt_d;
`endif

    logic [2:0]           ctrl_q, ctrl_d;
    logic [DATAWIDTH-1:0] load_q, load_d;
    logic [DATAWIDTH-1:0] value_q, value_d;
    logic                 intstat_q, intstat_d;

    logic                 setup_s;
    logic                 access_s;
    logic                 err_s;
    logic                 wr_commit_s;
    logic                 wr_ctrl_s;
    logic                 wr_load_s;
    logic                 wr_int_s;
    logic                 int_set_s;
    logic [DATAWIDTH-1:0] rdata_s;

    assign setup_s  = psel_i & ~penable_i;
    // An access phase only counts if a setup phase was tracked before it.
    assign access_s = psel_i & penable_i & ((state_q == StSetup) | (state_q == StAccess));

    assign err_s = (paddr_i[ADDRWIDTH-1:4] != '0) | (paddr_i[1:0] != 2'b00) |
                   (pwrite_i & (paddr_i[3:2] == AddrValue));

    assign wr_commit_s = pclken_i & access_s & pready_q & pwrite_i & ~err_q;
    assign wr_ctrl_s   = wr_commit_s & (paddr_i[3:2] == AddrCtrl);
    assign wr_load_s   = wr_commit_s & (paddr_i[3:2] == AddrLoad);
    assign wr_int_s    = wr_commit_s & (paddr_i[3:2] == AddrInt);

    always_comb begin
        rdata_s = '0;
        case (paddr_i[3:2])
            AddrCtrl:  rdata_s = {{(DATAWIDTH-3){1'b0}}, ctrl_q};
            AddrLoad:  rdata_s = load_q;
            AddrValue: rdata_s = value_q;
            AddrInt:   rdata_s = {{(DATAWIDTH-1){1'b0}}, intstat_q};
            default:   rdata_s = '0;
        endcase
    end

    // Timer and register-file next state; a LOAD write overrides the decrement.
    always_comb begin
        ctrl_d    = ctrl_q;
        load_d    = load_q;
        value_d   = value_q;
        intstat_d = intstat_q;
        int_set_s = 1'b0;
        if (pclken_i && ctrl_q[0]) begin
            if (value_q > DATAWIDTH'(1)) begin
                value_d = value_q - DATAWIDTH'(1);
            end else if (value_q == DATAWIDTH'(1)) begin
                int_set_s = 1'b1;
                value_d   = ctrl_q[2] ? load_q : '0;
            end
        end
        if (wr_ctrl_s) begin
            ctrl_d = pwdata_i[2:0];
        end
        if (wr_load_s) begin
            load_d  = pwdata_i;
            value_d = pwdata_i;
        end
        if (wr_int_s && pwdata_i[0]) begin
            intstat_d = 1'b0;
        end
        if (int_set_s) begin
            intstat_d = 1'b1;
        end
    end

    // APB handshake: PRDATA/PREADY/PSLVERR are registered for the following bus cycle.
    always_comb begin
        state_d   = state_q;
        prdata_d  = prdata_q;
        pready_d  = pready_q;
        pslverr_d = pslverr_q;
        err_d     = err_q;
`ifdef APB_SLV_WAIT_EN
        wait_cnt_d = wait_cnt_q;
`endif
        if (pclken_i) begin
            if (setup_s) begin
                state_d  = StSetup;
                err_d    = err_s;
                prdata_d = (!pwrite_i && !err_s) ? rdata_s : '0;
`ifdef APB_SLV_WAIT_EN
                wait_cnt_d = WaitLoad;
                pready_d   = (WaitLoad == 4'd0);
                pslverr_d  = err_s & (WaitLoad == 4'd0);
`else
                pready_d  = 1'b1;
                pslverr_d = err_s;
`endif
            end else if (access_s) begin
                if (pready_q) begin
                    state_d   = StIdle;
                    pready_d  = 1'b1;
                    pslverr_d = 1'b0;
                end else begin
                    state_d = StAccess;
                    if (!pwrite_i && !err_q) begin
                        prdata_d = rdata_s;
                    end
`ifdef APB_SLV_WAIT_EN
                    wait_cnt_d = wait_cnt_q - 4'd1;
                    if (wait_cnt_q == 4'd1) begin
                        pready_d  = 1'b1;
                        pslverr_d = err_q;
                    end
`endif
                end
            end else begin
                // Idle, or PSEL dropped mid-transfer: abandon without committing.
                state_d   = StIdle;
                pready_d  = 1'b1;
                pslverr_d = 1'b0;
            end
        end
    end

    always_ff @(posedge hclk_i or negedge hresetn_i) begin
        if (!hresetn_i) begin
            state_q   <= StIdle;
            prdata_q  <= '0;
            pready_q  <= 1'b1;
            pslverr_q <= 1'b0;
            err_q     <= 1'b0;
            ctrl_q    <= '0;
            load_q    <= '0;
            value_q   <= '0;
            intstat_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            err_q     <= err_d;
            ctrl_q    <= ctrl_d;
            load_q    <= load_d;
            value_q   <= value_d;
            intstat_q <= intstat_d;
        end
    end

`ifdef APB_SLV_WAIT_EN
    always_ff @(posedge hclk_i or negedge hresetn_i) begin
        if (!hresetn_i) begin
            wait_cnt_q <= 4'd0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`endif

    assign prdata_o   = prdata_q;
    assign pready_o   = pready_q;
    assign pslverr_o  = pslverr_q;
    assign timerint_o = intstat_q & ctrl_q[1];

endmodule

// File: tb/tb_apb_timer_slave.sv
// Randomised scoreboard bench for apb_timer_slave against a behavioural timer/register model.
module tb_apb_timer_slave;

    localparam int unsigned WS = 2;
`ifdef APB_SLV_WAIT_EN
    localparam int EXP_WAIT = WS;
`else
    localparam int EXP_WAIT = 0;
`endif

    logic        hclk;
    logic        rst_n;
    logic        pclken;
    logic        psel;
    logic        penable;
    logic [15:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        timerint;

    apb_timer_slave #(
        .ADDRWIDTH  (16),
        .DATAWIDTH  (32),
        .WAIT_STATES(WS)
    ) dut (
        .hclk_i    (hclk),
        .hresetn_i (rst_n),
        .pclken_i  (pclken),
        .psel_i    (psel),
        .penable_i (penable),
        .paddr_i   (paddr),
        .pwrite_i  (pwrite),
        .pwdata_i  (pwdata),
        .prdata_o  (prdata),
        .pready_o  (pready),
        .pslverr_o (pslverr),
        .timerint_o(timerint)
    );

    typedef struct packed {
        logic [31:0] d;
        logic        e;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;

    // Behavioural model state, and a copy taken just before each PCLKEN edge.
    logic [2:0]  m_ctrl, s_ctrl;
    logic [31:0] m_load, s_load, m_value, s_value;
    logic        m_int, s_int;

    logic        cm_valid = 1'b0;
    logic [15:0] cm_addr  = '0;
    logic [31:0] cm_data  = '0;
    logic        cm_err   = 1'b0;

    int          pmode = 0;
    int          phase = 0;

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    always begin
        @(posedge hclk);
        #1;
        case (pmode)
            0: pclken = 1'b1;
            1: begin
                phase  = (phase + 1) % 3;
                pclken = (phase == 0);
            end
            default: pclken = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    function automatic bit bench_err(input bit wr, input logic [15:0] a);
        return (a[15:4] != 12'd0) || (a[1:0] != 2'd0) || (wr && a[3:2] == 2'd2);
    endfunction

    function automatic logic [31:0] rd_model(input logic [15:0] a);
        case (a[3:2])
            2'd0:    return {29'd0, s_ctrl};
            2'd1:    return s_load;
            2'd2:    return s_value;
            default: return {31'd0, s_int};
        endcase
    endfunction

    always @(posedge hclk or negedge rst_n) begin
        logic [2:0]  c;
        logic [31:0] l;
        logic [31:0] v;
        logic        i;
        logic        set_now;
        if (!rst_n) begin
            m_ctrl <= '0; m_load <= '0; m_value <= '0; m_int <= 1'b0;
            s_ctrl <= '0; s_load <= '0; s_value <= '0; s_int <= 1'b0;
        end else if (pclken) begin
            c = m_ctrl; l = m_load; v = m_value; i = m_int;
            s_ctrl <= m_ctrl; s_load <= m_load; s_value <= m_value; s_int <= m_int;
            set_now = 1'b0;
            if (m_ctrl[0] && m_value != 0) begin
                if (m_value == 1) begin
                    set_now = 1'b1;
                    v = m_ctrl[2] ? m_load : 32'd0;
                end else begin
                    v = m_value - 1;
                end
            end
            if (set_now) i = 1'b1;
            if (cm_valid && !cm_err) begin
                case (cm_addr[3:2])
                    2'd0: c = cm_data[2:0];
                    2'd1: begin l = cm_data; v = cm_data; end
                    2'd3: if (cm_data[0] && !set_now) i = 1'b0;
                    default: ;
                endcase
            end
            m_ctrl <= c; m_load <= l; m_value <= v; m_int <= i;
        end
    end

    // Monitor: pops one expectation per completed transfer; also tracks the interrupt level.
    always begin
        exp_t e;
        @(negedge hclk);
        #1;
        if (rst_n) begin
            chk("timerint", {31'd0, timerint}, {31'd0, m_int & m_ctrl[1]});
            if (psel && penable && pready && pclken) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_completion", 32'd1, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("prdata", prdata, e.d);
                    chk("pslverr", {31'd0, pslverr}, {31'd0, e.e});
                end
            end
        end
    end

    task automatic xfer(input bit wr, input logic [15:0] a, input logic [31:0] d,
                        input bit fix, input logic [31:0] fixv);
        bit   err;
        bit   done;
        int   waits;
        int   guard;
        exp_t e;
        err = bench_err(wr, a);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        guard = 0;
        do begin
            @(posedge hclk);
            guard++;
        end while (!pclken && guard < 100);
        #1 penable = 1'b1;
        waits = 0; done = 1'b0; guard = 0;
        while (!done && guard < 200) begin
            @(negedge hclk);
            if (pready && pclken) begin
                e.d = (wr || err) ? 32'd0 : (fix ? fixv : rd_model(a));
                e.e = err;
                sbq.push_back(e);
                cm_valid = wr; cm_addr = a; cm_data = d; cm_err = err;
                done = 1'b1;
            end else if (!pready && pclken) begin
                waits++;
            end
            @(posedge hclk);
            guard++;
        end
        #1;
        cm_valid = 1'b0; psel = 1'b0; penable = 1'b0;
        if (!done) chk("xfer_timeout", 32'd1, 32'd0);
        chk("wait_states", 32'(waits), 32'(EXP_WAIT));
    endtask

    task automatic wr_reg(input logic [15:0] a, input logic [31:0] d);
        xfer(1'b1, a, d, 1'b0, 32'd0);
    endtask

    task automatic rd_reg(input logic [15:0] a);
        xfer(1'b0, a, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic idle(input int n);
        psel = 1'b0; penable = 1'b0;
        repeat (n) @(posedge hclk);
        #1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] addrs [8];
        logic [15:0] a;
        bit          wr;
        logic [31:0] d;
        addrs[0] = 16'h0000; addrs[1] = 16'h0004; addrs[2] = 16'h0008; addrs[3] = 16'h000C;
        addrs[4] = 16'h0010; addrs[5] = 16'h0002; addrs[6] = 16'h8004; addrs[7] = 16'h000E;

        rst_n = 1'b0; pclken = 1'b1; psel = 1'b0; penable = 1'b0;
        paddr = '0; pwrite = 1'b0; pwdata = '0;
        #12;
        chk("rst_prdata", prdata, 32'd0);
        chk("rst_pready", {31'd0, pready}, 32'd1);
        chk("rst_pslverr", {31'd0, pslverr}, 32'd0);
        chk("rst_timerint", {31'd0, timerint}, 32'd0);
        @(posedge hclk); #1 rst_n = 1'b1;
        idle(2);

        // Reset asserted in the access phase of a LOAD write.
        psel = 1'b1; pwrite = 1'b1; paddr = 16'h0004; pwdata = 32'hDEADBEEF; penable = 1'b0;
        @(posedge hclk); #1 penable = 1'b1;
        @(negedge hclk); rst_n = 1'b0;
        #1;
        chk("midrst_prdata", prdata, 32'd0);
        chk("midrst_pready", {31'd0, pready}, 32'd1);
        chk("midrst_pslverr", {31'd0, pslverr}, 32'd0);
        chk("midrst_timerint", {31'd0, timerint}, 32'd0);
        psel = 1'b0; penable = 1'b0;
        @(posedge hclk); #1 rst_n = 1'b1;
        idle(1);
        xfer(1'b0, 16'h0004, 32'd0, 1'b1, 32'd0);

        // One-shot countdown.
        wr_reg(16'h0004, 32'd5);
        wr_reg(16'h0000, 32'd3);
        repeat (4) rd_reg(16'h0008);
        idle(30);
        xfer(1'b0, 16'h0008, 32'd0, 1'b1, 32'd0);
        xfer(1'b0, 16'h000C, 32'd0, 1'b1, 32'd1);
        chk("oneshot_timerint", {31'd0, timerint}, 32'd1);

        // Periodic reload and interrupt clear.
        wr_reg(16'h0000, 32'd0);
        wr_reg(16'h000C, 32'd1);
        wr_reg(16'h0004, 32'd3);
        wr_reg(16'h0000, 32'd7);
        repeat (8) rd_reg(16'h0008);
        wr_reg(16'h000C, 32'd1);
        idle(4);

        // Error responses leave state untouched.
        wr_reg(16'h0000, 32'd0);
        wr_reg(16'h0004, 32'h0000_00A5);
        wr_reg(16'h0008, 32'h1234_5678);
        xfer(1'b0, 16'h0010, 32'd0, 1'b1, 32'd0);
        wr_reg(16'h0010, 32'hFFFF_FFFF);
        rd_reg(16'h0002);
        xfer(1'b0, 16'h0004, 32'd0, 1'b1, 32'h0000_00A5);
        xfer(1'b0, 16'h0008, 32'd0, 1'b1, 32'h0000_00A5);

        // INT clear committing on the same edge as the expiry tick: set wins.
        wr_reg(16'h000C, 32'd1);
        wr_reg(16'h0004, 32'(EXP_WAIT + 2));
        wr_reg(16'h0000, 32'd3);
        wr_reg(16'h000C, 32'd1);
        chk("same_edge_timerint", {31'd0, timerint}, 32'd1);
        xfer(1'b0, 16'h000C, 32'd0, 1'b1, 32'd1);

        // Sparse PCLKEN (1 of 3).
        pmode = 1;
        wr_reg(16'h0004, 32'd4);
        wr_reg(16'h0000, 32'd7);
        repeat (6) rd_reg(16'h0008);
        rd_reg(16'h000C);

        // Randomised traffic.
        for (int n = 0; n < 150; n++) begin
            if (n % 20 == 0) pmode = int'($urandom_range(0, 2));
            a  = addrs[$urandom_range(0, 7)];
            wr = 1'($urandom_range(0, 1));
            case (a[3:2])
                2'd0:    d = 32'($urandom_range(0, 7));
                2'd1:    d = 32'($urandom_range(0, 12));
                2'd3:    d = 32'($urandom_range(0, 1));
                default: d = $urandom;
            endcase
            xfer(wr, a, d, 1'b0, 32'd0);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end

        pmode = 0;
        idle(5);
        chk("sb_drain", 32'(sbq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
